// File: rtl/stimulus_for_crossbar4.sv
// Self-running 4-port request generator: LFSR-driven destinations and gaps,
// per-destination round-robin model decides how long each request is held.
//
// state   | meaning
// IDLE    | req low, gap_cnt counting down to the next request
// REQUEST | req high, waiting for the destination arbiter
// SERVICE | req high, burst_cnt counting the granted burst
module stimulus_for_crossbar4 #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          BURST_LEN = 4,
  parameter int          GAP_BASE  = 1
) (
  input  logic       clk,
  input  logic       hard_reset,
  output logic [3:0] req
);

  localparam int GW = ($clog2(GAP_BASE + 4) < 3) ? 3 : $clog2(GAP_BASE + 4);
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

  state_t              state     [4];
  state_t              state_nxt [4];
  logic [3:0][GW-1:0]  gap_cnt, gap_nxt;
  logic [3:0][BW-1:0]  burst_cnt, burst_nxt;
  logic [3:0][1:0]     dst, dst_nxt;
  logic [3:0][1:0]     ptr, ptr_nxt;
  logic [3:0]          busy, grant, req_nxt;
  logic [15:0]         lfsr, lfsr_nxt;

  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Busy comes from registered SERVICE state, so a destination released on
  // one edge is only re-granted on the following edge.
  always_comb begin
    busy    = '0;
    grant   = '0;
    ptr_nxt = ptr;
    for (int p = 0; p < 4; p++) begin
      if (state[p] == SERVICE) busy[dst[p]] = 1'b1;
    end
    for (int d = 0; d < 4; d++) begin
      logic       found;
      logic [1:0] cand;
      found = 1'b0;
      cand  = '0;
      if (!busy[d]) begin
        for (int k = 1; k <= 4; k++) begin
          cand = ptr[d] + 2'(k);
          if (!found && state[cand] == REQUEST && dst[cand] == 2'(d)) begin
            grant[cand] = 1'b1;
            ptr_nxt[d]  = cand;
            found       = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    burst_nxt = burst_cnt;
    dst_nxt   = dst;
    req_nxt   = '0;
    for (int p = 0; p < 4; p++) begin
      case (state[p])
        IDLE: begin
          if (gap_cnt[p] == '0) begin
            state_nxt[p] = REQUEST;
            dst_nxt[p]   = lfsr[2*p +: 2];
          end else begin
            gap_nxt[p] = gap_cnt[p] - GW'(1);
          end
        end
        REQUEST: begin
          if (grant[p]) begin
            state_nxt[p] = SERVICE;
            burst_nxt[p] = BW'(BURST_LEN);
          end
        end
        SERVICE: begin
          if (burst_cnt[p] == BW'(1)) begin
            state_nxt[p] = IDLE;
            gap_nxt[p]   = GW'(GAP_BASE) + GW'(lfsr[2*p+8 +: 2]);
          end else if (burst_cnt[p] != '0) begin
            burst_nxt[p] = burst_cnt[p] - BW'(1);
          end
        end
        default: state_nxt[p] = IDLE;
      endcase
      req_nxt[p] = (state_nxt[p] != IDLE);
    end
  end

  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      for (int p = 0; p < 4; p++) begin
        state[p]     <= IDLE;
        gap_cnt[p]   <= GW'(p);
        burst_cnt[p] <= '0;
        dst[p]       <= '0;
        ptr[p]       <= 2'd3;
      end
      lfsr <= SEED;
      req  <= '0;
    end else begin
      state     <= state_nxt;
      gap_cnt   <= gap_nxt;
      burst_cnt <= burst_nxt;
      dst       <= dst_nxt;
      ptr       <= ptr_nxt;
      lfsr      <= lfsr_nxt;
      req       <= req_nxt;
    end
  end

endmodule

// File: tb/tb_stimulus_for_crossbar4.sv
// Bench for stimulus_for_crossbar4: cycle-by-cycle compare of req and the LFSR
// against a behavioural traffic model, with randomized reset episodes.
module tb_stimulus_for_crossbar4;

  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          BURST_LEN = 4;
  localparam int          GAP_BASE  = 1;
  localparam int          TRACE_LEN = 200;

  logic       clk;
  logic       hard_reset;
  logic [3:0] req;

  int n_cmp = 0;
  int n_bad = 0;

  stimulus_for_crossbar4 #(.SEED(SEED), .BURST_LEN(BURST_LEN), .GAP_BASE(GAP_BASE)) dut (
    .clk        (clk),
    .hard_reset (hard_reset),
    .req        (req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode 0 = waiting out a gap, 1 = asking, 2 = holding a burst.
  int          m_mode [4];
  int          m_left [4];
  int          m_dst  [4];
  int          m_ptr  [4];
  int unsigned m_lfsr;
  logic [3:0]  trace1 [TRACE_LEN];

  function automatic void model_reset();
    for (int p = 0; p < 4; p++) begin
      m_mode[p] = 0;
      m_left[p] = p;
      m_dst[p]  = 0;
      m_ptr[p]  = 3;
    end
    m_lfsr = SEED;
  endfunction

  function automatic void model_step();
    int winner [4];
    bit taken  [4];
    for (int d = 0; d < 4; d++) begin
      winner[d] = -1;
      taken[d]  = 0;
    end
    for (int p = 0; p < 4; p++)
      if (m_mode[p] == 2) taken[m_dst[p]] = 1;
    for (int d = 0; d < 4; d++) begin
      if (!taken[d]) begin
        for (int k = 1; k <= 4 && winner[d] < 0; k++) begin
          int p;
          p = (m_ptr[d] + k) % 4;
          if (m_mode[p] == 1 && m_dst[p] == d) winner[d] = p;
        end
        if (winner[d] >= 0) m_ptr[d] = winner[d];
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (m_mode[p] == 0) begin
        if (m_left[p] == 0) begin
          m_mode[p] = 1;
          m_dst[p]  = (m_lfsr >> (2 * p)) % 4;
        end else m_left[p]--;
      end else if (m_mode[p] == 1) begin
        if (winner[m_dst[p]] == p) begin
          m_mode[p] = 2;
          m_left[p] = BURST_LEN;
        end
      end else begin
        if (m_left[p] == 1) begin
          m_mode[p] = 0;
          m_left[p] = GAP_BASE + ((m_lfsr >> (2 * p + 8)) % 4);
        end else m_left[p]--;
      end
    end
    m_lfsr = (m_lfsr / 2) ^ ((m_lfsr % 2 == 1) ? 32'hB400 : 32'h0);
  endfunction

  function automatic logic [3:0] model_req();
    logic [3:0] r;
    for (int p = 0; p < 4; p++) r[p] = (m_mode[p] != 0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of traffic; run 0 records the trace, run 1 replays against it.
  task automatic run_cycles(input int n, input int run);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("req", {28'd0, req}, {28'd0, model_req()});
      chk("lfsr", {16'd0, dut.lfsr}, m_lfsr);
      chk("lfsr_nonzero", {31'd0, dut.lfsr != 16'h0}, 32'd1);
      if (run == 0 && k <= TRACE_LEN) trace1[k-1] = req;
      if (run == 1 && k <= TRACE_LEN) chk("repeat", {28'd0, req}, {28'd0, trace1[k-1]});
      if (run == 0) begin
        if (k == 1) begin
          chk("stagger1", {28'd0, req}, 32'h1);
          chk("dst0", {30'd0, dut.dst[0]}, 32'h1);
          chk("lfsr_e1", {16'd0, dut.lfsr}, 32'hE270);
        end
        if (k == 2) chk("stagger2", {28'd0, req}, 32'h3);
        if (k == 3) chk("stagger3", {28'd0, req}, 32'h7);
        if (k == 4) chk("stagger4", {28'd0, req}, 32'hF);
        if (k == 5) chk("burst_hold", {31'd0, req[0]}, 32'd1);
        if (k == 6) chk("burst_end", {31'd0, req[0]}, 32'd0);
      end
    end
  endtask

  task automatic hold_reset(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      chk("rst_req", {28'd0, req}, 32'h0);
    end
    hard_reset = 1'b1;
  endtask

  task automatic async_reset(input int offset);
    @(posedge clk);
    model_step();
    #(offset);
    hard_reset = 1'b0;
    model_reset();
    #1;
    chk("async_clr", {28'd0, req}, 32'h0);
  endtask

  initial begin
    hard_reset = 1'b0;
    model_reset();
    #1;
    chk("rst_t0", {28'd0, req}, 32'h0);
    hold_reset(4);
    chk("lfsr_seed", {16'd0, dut.lfsr}, SEED);

    run_cycles(TRACE_LEN, 0);
    async_reset(3);
    hold_reset(90);
    run_cycles(TRACE_LEN, 1);

    async_reset(2);
    hold_reset(3);
    run_cycles(4, 2);
    async_reset(4);
    hold_reset(90);
    run_cycles(TRACE_LEN, 1);

    for (int e = 0; e < 8; e++) begin
      run_cycles($urandom_range(5, 150), 2);
      async_reset($urandom_range(1, 8));
      hold_reset($urandom_range(1, 10));
    end
    run_cycles(100, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stimulus_for_crossbar4.md
# stimulus_for_crossbar4

Self-running request-stimulus generator for the 4-port crossbar switch. It drives a 4-bit request vector with pseudo-random, repeatable traffic. An internal model of a destination-contention arbiter decides how long each request is held. The block sits in the crossbar test environment in place of real traffic sources; its only inputs are clock and reset.

## Interface
- SEED, 16'hACE1: reset value of the 16-bit LFSR; must be non-zero.
- BURST_LEN, 4: cycles a granted port stays in SERVICE (1..15).
- GAP_BASE, 1: minimum idle cycles between a port's requests (1..15).
- clk  input  1  system clock, rising-edge.
- hard_reset  input  1  reset. One clock; reset is asynchronous and active-low.
- req  output  4  per-port request lines; registered; bit i belongs to port i.

## Operation
- LFSR: 16-bit Galois, right-shifting, mask 16'hB400.
  - Update rule: next = (l >> 1) ^ (l[0] ? 16'hB400 : 0).
  - Advances on every clock edge out of reset.
  - SEED 0xACE1 is followed by 0xE270.
  - Decisions on an edge use the pre-edge LFSR value.
- Per-port FSM, i = 0..3, with states IDLE, REQUEST and SERVICE.
  - req[i] = 1 in REQUEST and SERVICE, and 0 in IDLE.
  - IDLE:
    - If gap_cnt[i] == 0, go to REQUEST. Latch dst[i] = lfsr[2i+1:2i].
    - Otherwise decrement gap_cnt[i].
  - REQUEST:
    - Wait for a grant from the arbiter for dst[i].
    - On grant, go to SERVICE with burst_cnt = BURST_LEN.
  - SERVICE:
    - If burst_cnt == 1, go to IDLE with gap_cnt[i] = GAP_BASE + lfsr[2i+9:2i+8].
    - Otherwise decrement burst_cnt.
- Arbitration: one round-robin arbiter per destination d = 0..3.
  - Destination d is busy if any port is currently in SERVICE with dst == d. Busy is evaluated from registered state.
  - If d is not busy, grant one REQUEST port with dst == d. Priority is rotating and starts after ptr[d], then ptr[d] <= the granted port.
  - Reset value of ptr[d] is 3, so port 0 has highest priority first.
  - A destination released on edge t can be re-granted no earlier than edge t+1, i.e. at least one free cycle.
  - A port never receives two grants; each port requests only one destination.
- Widths:
  - gap_cnt is 3 bits minimum; size it to hold GAP_BASE+3.
  - burst_cnt holds BURST_LEN.
  - Counters never wrap; they stop at their terminal value.

## Timing
- Reset (hard_reset = 0), asynchronous and immediate:
  - req = 4'b0000.
  - All ports IDLE, with gap_cnt[i] = i.
  - LFSR = SEED; ptr = 3.
- Reset deassertion takes effect at the first rising edge with hard_reset = 1.
- Port i asserts req[i] after edge i+1 following release (staggered start).
- Latency:
  - Request to grant is at least 1 edge.
  - A granted request is held exactly BURST_LEN cycles after the grant edge.
  - Idle gap is GAP_BASE..GAP_BASE+3 cycles plus 1 cycle of exit.
- Reset reasserted mid-burst: req clears in the same instant, no clock needed, and the sequence restarts identically on release. Traffic is fully deterministic for a given SEED.
- Simultaneous requests to one free destination: exactly one grant per edge; the others stay in REQUEST with req held at 1.

## Test plan
- Reset: hold hard_reset = 0 for 40 ns with clk at 10 ns period.
  - Required: req = 0000 throughout.
  - Required: asynchronous assertion mid-cycle clears req without waiting for a clock edge.
- Staggered start with default parameters:
  - Required: req = 0001, 0011, 0111, 1111 after edges 1, 2, 3, 4 from release.
  - Required: port 0 has dst = 1 (from SEED[1:0] = 01).
- Burst length: port 0 alone on destination 1, granted at edge 2.
  - Required: req[0] stays 1 through edge 5 and falls after edge 6.
  - Required: it then stays 0 for GAP_BASE + lfsr[9:8] + 1 cycles.
- Contention: force two ports onto the same destination.
  - Required: they are served alternately by round-robin.
  - Required: service periods never overlap.
  - Required: at least one free cycle separates consecutive services.
- Repeatability: reset for 900 ns after 40 ns of traffic, then release again.
  - Required: the req trace is bit-identical to the first run.
- LFSR check: after release, the internal LFSR sequence is 0xACE1, then 0xE270, and it never reaches 0.
